// File: rtl/control_sequencer_if.sv
// Sequencer <-> decoder/datapath bundle: IR/databus in, decoder results in, issued control out.
// Latency: pure wiring, no storage.
// Backpressure: stall is carried here and freezes the sequencer for the cycle it is high.
interface control_sequencer_if;
    logic [31:0] instruction_in;
    logic [4:0]  status_in;
    logic        stall;
    logic [32:0] decoded_controlword;
    logic [63:0] decoded_constant;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] controlword;
    logic [63:0] constant;
    logic        ir_load;
    logic        fetch;
    logic        fault;

    // Sequencer side
    modport master (
        input  instruction_in, status_in, stall, decoded_controlword, decoded_constant,
        output instruction, state, status, controlword, constant, ir_load, fetch, fault
    );

    // Decoder / datapath side
    modport slave (
        output instruction_in, status_in, stall, decoded_controlword, decoded_constant,
        input  instruction, state, status, controlword, constant, ir_load, fetch, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// FETCH/EXECUTE micro-sequencer: owns IR, micro-step, status register and an EXECUTE watchdog.
// Latency: control word/constant issued combinationally from the decoder in EXECUTE; state updates on the next edge.
// Backpressure: stall holds all state and masks side-effecting control fields for that cycle.
module control_sequencer #(
    parameter int WATCHDOG_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,
    control_sequencer_if.master bus
);
    localparam int WD_W = $clog2(WATCHDOG_LIMIT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_LIMIT - 1);
    // Fetch word: only ram_en set; PC holds and is advanced by the instruction itself.
    localparam logic [32:0] FETCH_WORD = 33'h0_0000_0100;

    // Control word bit positions that have side effects and are suppressed on stall.
    localparam int CW_RF_WRITE    = 9;
    localparam int CW_RAM_WRITE   = 7;
    localparam int CW_PC_FS_HI    = 5;
    localparam int CW_PC_FS_LO    = 4;
    localparam int CW_STATUS_LOAD = 2;

    typedef enum logic {
        PH_FETCH   = 1'b0,
        PH_EXECUTE = 1'b1
    } phase_e;

    phase_e          phase_q, phase_d;
    logic [31:0]     ir_q, ir_d;
    logic [1:0]      step_q, step_d;
    logic [4:0]      status_q, status_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            fault_q, fault_d;

    logic [32:0]     cw_issue;
    logic [63:0]     const_issue;
    logic            ir_load_c;
    logic [1:0]      next_step;

    assign next_step = bus.decoded_controlword[1:0];

    // Issued control word / constant / IR strobe for the current cycle.
    always_comb begin
        cw_issue    = '0;
        const_issue = '0;
        ir_load_c   = 1'b0;
        if (!reset) begin
            if (phase_q == PH_FETCH) begin
                cw_issue  = FETCH_WORD;
                ir_load_c = !bus.stall;
            end else begin
                cw_issue    = bus.decoded_controlword;
                const_issue = bus.decoded_constant;
                if (bus.stall) begin
                    cw_issue[CW_RF_WRITE]               = 1'b0;
                    cw_issue[CW_RAM_WRITE]              = 1'b0;
                    cw_issue[CW_PC_FS_HI:CW_PC_FS_LO]   = 2'b00;
                    cw_issue[CW_STATUS_LOAD]            = 1'b0;
                end
            end
        end
    end

    // Next-state: phase transitions, IR capture, micro-step, status load and watchdog.
    always_comb begin
        phase_d  = phase_q;
        ir_d     = ir_q;
        step_d   = step_q;
        status_d = status_q;
        wdog_d   = wdog_q;
        fault_d  = fault_q;
        if (!bus.stall) begin
            case (phase_q)
                PH_FETCH: begin
                    phase_d = PH_EXECUTE;
                    ir_d    = bus.instruction_in;
                    step_d  = 2'd0;
                    wdog_d  = '0;
                end
                PH_EXECUTE: begin
                    wdog_d = wdog_q + 1'b1;
                    if (bus.decoded_controlword[CW_STATUS_LOAD]) begin
                        status_d = bus.status_in;
                    end
                    if (next_step == 2'd0) begin
                        phase_d = PH_FETCH;
                        step_d  = 2'd0;
                    end else if (wdog_q == WD_LAST) begin
                        // Instruction never finished: abandon it and flag it.
                        phase_d = PH_FETCH;
                        step_d  = 2'd0;
                        fault_d = 1'b1;
                    end else begin
                        step_d = next_step;
                    end
                end
                default: phase_d = PH_FETCH;
            endcase
        end
    end

    // State register with synchronous reset that overrides stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= PH_FETCH;
            ir_q     <= '0;
            step_q   <= 2'd0;
            status_q <= '0;
            wdog_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            ir_q     <= ir_d;
            step_q   <= step_d;
            status_q <= status_d;
            wdog_q   <= wdog_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.instruction = ir_q;
    assign bus.state       = step_q;
    assign bus.status      = status_q;
    assign bus.controlword = cw_issue;
    assign bus.constant    = const_issue;
    assign bus.ir_load     = ir_load_c;
    assign bus.fetch       = (phase_q == PH_FETCH);
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios then random traffic against a behavioural model.
// Latency: one expectation per cycle, compared on the falling edge of the same cycle.
// Backpressure: stall is randomised and its masking is part of the model.
module tb_control_sequencer;
    localparam int LIMIT = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    control_sequencer_if bus();

    control_sequencer #(.WATCHDOG_LIMIT(LIMIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [32:0] cw;
        logic [63:0] k;
        logic        ir_load;
        logic        fetch;
        logic [31:0] instr;
        logic [1:0]  st;
        logic [4:0]  status;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: which phase, what IR holds, which step, how many EXECUTE cycles so far.
    bit          m_in_fetch;
    logic [31:0] m_ir;
    int          m_step;
    logic [4:0]  m_status;
    int          m_execs;
    bit          m_fault;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] mk(input logic [1:0] ns, input bit sl, input bit rfw,
                                       input logic [1:0] pcfs);
        logic [63:0] r;
        logic [32:0] w;
        r = {$urandom(), $urandom()};
        w = r[32:0];
        w[1:0] = ns;
        w[2]   = sl;
        w[9]   = rfw;
        w[5:4] = pcfs;
        return w;
    endfunction

    function automatic logic [63:0] rk();
        return {$urandom(), $urandom()};
    endfunction

    // One clock cycle of stimulus: drive, queue the expected response, advance the model.
    task automatic cycle(input bit rst, input bit stl, input logic [31:0] ins,
                         input logic [32:0] dcw, input logic [63:0] dk, input logic [4:0] sin);
        exp_t e;
        reset                   = rst;
        bus.stall               = stl;
        bus.instruction_in      = ins;
        bus.decoded_controlword = dcw;
        bus.decoded_constant    = dk;
        bus.status_in           = sin;

        e.instr  = m_ir;
        e.st     = m_step[1:0];
        e.status = m_status;
        e.fault  = m_fault;
        e.fetch  = m_in_fetch;
        if (rst) begin
            e.cw = '0; e.k = '0; e.ir_load = 1'b0;
        end else if (m_in_fetch) begin
            e.cw = 33'd1 << 8; e.k = '0; e.ir_load = !stl;
        end else begin
            e.cw = dcw; e.k = dk; e.ir_load = 1'b0;
            if (stl) begin
                e.cw[9] = 1'b0; e.cw[7] = 1'b0; e.cw[5:4] = 2'b00; e.cw[2] = 1'b0;
            end
        end
        sb.push_back(e);

        @(posedge clock);
        if (rst) begin
            m_in_fetch = 1; m_ir = '0; m_step = 0; m_status = '0; m_execs = 0; m_fault = 0;
        end else if (!stl) begin
            if (m_in_fetch) begin
                m_ir = ins; m_step = 0; m_execs = 0; m_in_fetch = 0;
            end else begin
                m_execs++;
                if (dcw[2]) m_status = sin;
                if (dcw[1:0] == 2'd0) begin
                    m_in_fetch = 1; m_step = 0;
                end else if (m_execs == LIMIT) begin
                    m_in_fetch = 1; m_step = 0; m_fault = 1;
                end else begin
                    m_step = int'(dcw[1:0]);
                end
            end
        end
        #1;
    endtask

    // Monitor: every cycle presents a full output set; compare it with the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("controlword", 64'(bus.controlword), 64'(e.cw));
                chk("constant",    bus.constant,         e.k);
                chk("ir_load",     64'(bus.ir_load),     64'(e.ir_load));
                chk("fetch",       64'(bus.fetch),       64'(e.fetch));
                chk("instruction", 64'(bus.instruction), 64'(e.instr));
                chk("state",       64'(bus.state),       64'(e.st));
                chk("status",      64'(bus.status),      64'(e.status));
                chk("fault",       64'(bus.fault),       64'(e.fault));
            end
        end
    end

    initial begin : stimulus
        logic [32:0] w;
        logic [31:0] ins;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.instruction_in = '0;
        bus.decoded_controlword = '0;
        bus.decoded_constant = '0;
        bus.status_in = '0;
        repeat (2) @(posedge clock);
        #1;
        m_in_fetch = 1; m_ir = '0; m_step = 0; m_status = '0; m_execs = 0; m_fault = 0;

        // Reset state observed while reset is still held, with stall asserted.
        cycle(1, 1, 32'h1234_5678, mk(2'b01, 1, 1, 2'b11), rk(), 5'h1F);

        // Single-step instruction: FETCH, one EXECUTE, FETCH.
        cycle(0, 0, 32'hB400_0041, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'hDEAD_BEEF, mk(2'b00, 0, 1, 2'b11), rk(), 5'h00);
        chk("req030_ir", 64'(bus.instruction), 64'h0000_0000_B400_0041);
        chk("req030_fetch", 64'(bus.fetch), 64'd1);

        // Three-step instruction: steps 0,1,2.
        cycle(0, 0, 32'h0000_0003, mk(2'b01, 0, 0, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b01, 0, 1, 2'b01), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b10, 0, 1, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b00, 0, 0, 2'b11), rk(), 5'h00);

        // Stall mid-EXECUTE masks rf_write and branch, then resumes unchanged.
        cycle(0, 0, 32'h0000_0032, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b01, 0, 0, 2'b00), rk(), 5'h00);
        w = mk(2'b10, 0, 1, 2'b11);
        repeat (3) cycle(0, 1, 32'hFFFF_FFFF, w, 64'h0123_4567_89AB_CDEF, 5'h1F);
        cycle(0, 0, 32'hFFFF_FFFF, w, 64'h0123_4567_89AB_CDEF, 5'h1F);
        cycle(0, 0, 32'h0, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);

        // Status load vs. hold.
        cycle(0, 0, 32'h0000_0033, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b01, 1, 0, 2'b00), rk(), 5'b00001);
        cycle(0, 0, 32'h0, mk(2'b00, 0, 0, 2'b00), rk(), 5'b11110);
        chk("req033_status", 64'(bus.status), 64'd1);

        // Watchdog: never-ending instruction forced out after LIMIT EXECUTE cycles.
        cycle(0, 0, 32'h0000_0034, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        repeat (LIMIT) cycle(0, 0, 32'h0, mk(2'b01, 0, 0, 2'b00), rk(), 5'h00);
        chk("req034_fetch", 64'(bus.fetch), 64'd1);
        chk("req034_fault", 64'(bus.fault), 64'd1);
        cycle(0, 0, 32'h0000_0035, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        chk("req034_sticky", 64'(bus.fault), 64'd1);

        // Reset in micro-step 2 discards the instruction.
        cycle(0, 0, 32'h0000_0036, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);
        cycle(0, 0, 32'h0, mk(2'b10, 1, 0, 2'b00), rk(), 5'h0A);
        cycle(1, 0, 32'h0, mk(2'b01, 1, 1, 2'b11), rk(), 5'h1F);
        chk("req035_state", 64'(bus.state), 64'd0);
        cycle(0, 0, 32'h0000_0037, mk(2'b00, 0, 0, 2'b00), rk(), 5'h00);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            ins = $urandom();
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, ins,
                  mk(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))),
                  rk(), 5'($urandom_range(0, 31)));
        end

        #10;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001: Parameter WATCHDOG_LIMIT, default 4, SHALL set the maximum consecutive EXECUTE cycles per instruction before forced fetch.
REQ-002: clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003: reset  input  1  SHALL be synchronous, active-high reset.
REQ-004: instruction_in  input  32  SHALL be the databus value captured into IR at end of a FETCH cycle.
REQ-005: status_in  input  5  SHALL be ALU flags {V,C,N,Z,zero-detect}; bit 0 is the register-zero flag used by CBZ/CBNZ.
REQ-006: stall  input  1  SHALL freeze the sequencer for the current cycle (memory wait).
REQ-007: decoded_controlword  input  33  SHALL be the selected opcode decoder's control word for (instruction, state, status).
REQ-008: decoded_constant  input  64  SHALL be the selected decoder's sign-extended constant.
REQ-009: instruction  output  32  SHALL be the IR contents fed to all decoders.
REQ-010: state  output  2  SHALL be the current micro-step fed to decoders.
REQ-011: status  output  5  SHALL be the status register contents fed to decoders.
REQ-012: controlword  output  33  SHALL be the control word issued to the datapath.
REQ-013: constant  output  64  SHALL be the constant issued to the datapath.
REQ-014: ir_load  output  1  SHALL pulse high in a non-stalled FETCH cycle.
REQ-015: fetch  output  1  SHALL be high while in FETCH.
REQ-016: fault  output  1  SHALL be a sticky watchdog-expiry flag.

Function
REQ-017: Control word field order, MSB to LSB, SHALL be: alu_en[32], alu_b_sel[31], alu_fs[30:26], rf_b_en[25], sa[24:20], sb[19:15], da[14:10], rf_write[9], ram_en[8], ram_write[7], pc_en[6], pc_fs[5:4], pc_in_sel[3], status_load[2], next_state[1:0].
REQ-018: Phases SHALL be FETCH and EXECUTE, plus a 2-bit micro-step register and a watchdog counter (clog2(WATCHDOG_LIMIT)+1 bits).
REQ-019: In FETCH, controlword SHALL be the fixed fetch word: ram_en=1, all other fields 0 (pc_fs=00, PC holds; PC advances in EXECUTE), and constant SHALL be 0.
REQ-020: Non-stalled FETCH SHALL load IR from instruction_in, set micro-step=0, clear watchdog, and move to EXECUTE next cycle.
REQ-021: In EXECUTE, controlword SHALL equal decoded_controlword and constant SHALL equal decoded_constant, combinationally (zero added latency).
REQ-022: Non-stalled EXECUTE with decoded next_state==00 SHALL return to FETCH; otherwise micro-step <= next_state and phase stays EXECUTE.
REQ-023: Watchdog SHALL increment on each non-stalled EXECUTE cycle; if the cycle would be the WATCHDOG_LIMIT-th consecutive one and next_state!=00, phase SHALL go to FETCH, micro-step to 0, and fault SHALL set.
REQ-024: Status register SHALL load status_in at the edge ending any non-stalled EXECUTE cycle whose issued status_load bit is 1; otherwise it holds.
REQ-025: When stall=1: phase, IR, micro-step, status, watchdog SHALL hold; ir_load=0; issued rf_write, ram_write, status_load SHALL be forced 0 and pc_fs forced 00, all other fields passed unchanged.
REQ-026: A branch (pc_fs=11) SHALL be issued for exactly one non-stalled cycle per instruction; no extra cycle is inserted for taken vs. not-taken.

Reset
REQ-027: While reset=1, controlword and constant SHALL be all zeros and ir_load=0.
REQ-028: On reset: phase=FETCH, IR=0, micro-step=0, status=0, watchdog=0, fault=0; reset overrides stall and applies mid-instruction, discarding the in-flight micro-step.
REQ-029: The first cycle after reset deasserts SHALL be a FETCH cycle.

Verification
REQ-030: Reset then instruction_in=32'hB400_0041, decoder word next_state=00 -> FETCH (ir_load=1), one EXECUTE issuing decoded word, FETCH again; instruction=32'hB400_0041.
REQ-031: Decoder returns next_state 01, 10, 00 on successive steps -> state output 0,1,2 across three EXECUTE cycles, then FETCH.
REQ-032: stall=1 for 3 cycles mid-EXECUTE with decoded rf_write=1, pc_fs=11 -> issued rf_write=0, pc_fs=00, state/IR unchanged; resumes identically on stall=0.
REQ-033: EXECUTE word status_load=1, status_in=5'b00001 -> status=5'b00001 next cycle; status_load=0 with status_in=5'b11110 -> status unchanged.
REQ-034: Decoder always returns next_state=01 -> forced FETCH after 4 EXECUTE cycles, fault=1 and stays 1 until reset.
REQ-035: reset asserted in micro-step 2 -> next cycle controlword=0, state=0, status=0; after release, FETCH.
